// File: rtl/bus6502_responder.sv
// Target end of the 6502 CPU bus: decodes phi2-framed cycles into on-chip RAM
// and a 3-register I/O page (LEDs, button status, cycle tick counter).
module bus6502_responder #(
  parameter int unsigned RAM_AWIDTH = 11,
  parameter logic [15:0] IO_BASE    = 16'hD000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        overrun,
  input  logic        btn1,
  input  logic        btn2,
  output logic [5:0]  led
);

  // state    | meaning
  // IDLE     | waiting for a qualified phi2 rise
  // ACCESS   | address/rw latched; RAM read issued on reads
  // RDATA    | read data loaded into rdata
  // WAITFALL | waiting for end of phase; writes commit here
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RDATA    = 2'd2,
    WAITFALL = 2'd3
  } state_t;

  localparam int unsigned RAM_DEPTH = 1 << RAM_AWIDTH;
  localparam logic [15:0] IO_LED    = IO_BASE;
  localparam logic [15:0] IO_BTN    = IO_BASE + 16'd1;
  localparam logic [15:0] IO_TICK   = IO_BASE + 16'd2;

  state_t      state_q;
  logic        phi2_d_q;
  logic        armed_q;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        overrun_q;

  logic [7:0]  mem_q [RAM_DEPTH];
  logic [7:0]  ram_rdata_q;
  logic [5:0]  led_reg_q;
  logic [5:0]  led_q;
  logic [7:0]  tick_q, tick_d;

  logic [1:0]  btn_s1_q, btn_s2_q, btn_prev_q;
  logic [1:0]  lat_q, lat_d;

  logic        rise, phase_over;
  logic        sel_ram, sel_led, sel_btn, sel_tick;
  logic        wr_commit, lat_clr;
  logic [7:0]  btn_status;
  logic [7:0]  rd_mux;

  // armed_q blocks a false rise when phi2 is already high as reset releases
  assign rise       = phi2 & ~phi2_d_q & armed_q;
  assign phase_over = ~phi2;

  assign sel_ram  = (addr_q >> RAM_AWIDTH) == 16'd0;
  assign sel_led  = addr_q == IO_LED;
  assign sel_btn  = addr_q == IO_BTN;
  assign sel_tick = addr_q == IO_TICK;

  assign wr_commit = (state_q == WAITFALL) && phase_over && !rw_q;
  assign lat_clr   = (state_q == RDATA) && rw_q && sel_btn;

  assign btn_status = {2'b00, lat_q[1], lat_q[0], 2'b00, ~btn_s2_q[1], ~btn_s2_q[0]};

  always_comb begin
    rd_mux = 8'hFF;
    if (sel_ram)       rd_mux = ram_rdata_q;
    else if (sel_led)  rd_mux = {2'b00, led_reg_q};
    else if (sel_btn)  rd_mux = btn_status;
    else if (sel_tick) rd_mux = tick_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phi2_d_q <= 1'b0;
      armed_q  <= 1'b0;
      wdata_q  <= 8'h00;
    end else begin
      phi2_d_q <= phi2;
      armed_q  <= armed_q | ~phi2;
      if (phi2) wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0000;
      rw_q      <= 1'b1;
      rdata_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            addr_q  <= addr;
            rw_q    <= rw;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          state_q <= rw_q ? RDATA : WAITFALL;
        end
        RDATA: begin
          rdata_q <= rd_mux;
          if (!phi2) begin
            overrun_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            state_q   <= WAITFALL;
          end
        end
        WAITFALL: begin
          if (phase_over) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && rw_q && sel_ram)
      ram_rdata_q <= mem_q[addr_q[RAM_AWIDTH-1:0]];
    if (wr_commit && sel_ram)
      mem_q[addr_q[RAM_AWIDTH-1:0]] <= wdata_q;
  end

  always_comb begin
    tick_d = tick_q;
    if (wr_commit && sel_tick) tick_d = 8'h00;
    else if (rise)             tick_d = tick_q + 8'd1;
  end

  // a press event in the same cycle as a clearing read keeps the latch set
  always_comb begin
    lat_d = (btn_prev_q & ~btn_s2_q) | (lat_clr ? 2'b00 : lat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg_q  <= 6'h00;
      led_q      <= 6'h3F;
      tick_q     <= 8'h00;
      btn_s1_q   <= 2'b11;
      btn_s2_q   <= 2'b11;
      btn_prev_q <= 2'b11;
      lat_q      <= 2'b00;
    end else begin
      if (wr_commit && sel_led) led_reg_q <= wdata_q[5:0];
      led_q      <= ~led_reg_q;
      tick_q     <= tick_d;
      btn_s1_q   <= {btn2, btn1};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      lat_q      <= lat_d;
    end
  end

  assign rdata   = rdata_q;
  assign overrun = overrun_q;
  assign led     = led_q;

endmodule

// File: tb/tb_bus6502_responder.sv
// Directed bench for bus6502_responder: RAM, LED, buttons, tick counter,
// overrun and reset behaviour with hand-computed expected values.
module tb_bus6502_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        phi2;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        overrun;
  logic        btn1, btn2;
  logic [5:0]  led;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd_mid, rd_end;
  int         ovr;

  bus6502_responder #(.RAM_AWIDTH(11), .IO_BASE(16'hD000)) dut (
    .clk     (clk),
    .rst     (rst),
    .phi2    (phi2),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .rdata   (rdata),
    .overrun (overrun),
    .btn1    (btn1),
    .btn2    (btn2),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: phi2 high for hi_len edges, then low for 4 edges.
  // rd_m is rdata right after the third high edge (rise edge + 2).
  task automatic bus_cycle(input logic r, input logic [15:0] a, input logic [7:0] d,
                           input int hi_len, output logic [7:0] rd_m,
                           output logic [7:0] rd_e, output int n_ovr);
    n_ovr = 0;
    rd_m  = 8'hxx;
    @(negedge clk);
    addr = a; rw = r; wdata = d; phi2 = 1'b1;
    for (int i = 0; i < hi_len; i++) begin
      @(posedge clk); #1;
      if (i == 2) rd_m = rdata;
      if (overrun) n_ovr++;
    end
    @(negedge clk);
    phi2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (overrun) n_ovr++;
    end
    rd_e = rdata;
  endtask

  initial begin
    rst = 1'b1; phi2 = 1'b0; addr = 16'h0; rw = 1'b1; wdata = 8'h0;
    btn1 = 1'b1; btn2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", led, 6'h3F);
    check("rst_rdata", rdata, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    bus_cycle(1'b1, 16'hD002, 8'h00, 13, rd_mid, rd_end, ovr);
    check("tick_first", rd_mid, 8'h01);

    // RAM
    bus_cycle(1'b0, 16'h0123, 8'hA5, 13, rd_mid, rd_end, ovr);
    bus_cycle(1'b1, 16'h0123, 8'h00, 13, rd_mid, rd_end, ovr);
    check("ram_0123", rd_mid, 8'hA5);
    check("ram_no_ovr", ovr, 0);
    bus_cycle(1'b0, 16'h07FF, 8'h5A, 13, rd_mid, rd_end, ovr);
    bus_cycle(1'b1, 16'h07FF, 8'h00, 13, rd_mid, rd_end, ovr);
    check("ram_07ff", rd_mid, 8'h5A);
    bus_cycle(1'b1, 16'h0800, 8'h00, 13, rd_mid, rd_end, ovr);
    check("unmapped_0800", rd_mid, 8'hFF);
    check("rdata_hold", rd_end, 8'hFF);

    // LED register
    bus_cycle(1'b0, 16'hD000, 8'h15, 13, rd_mid, rd_end, ovr);
    check("led_pins_15", led, 6'b101010);
    bus_cycle(1'b1, 16'hD000, 8'h00, 13, rd_mid, rd_end, ovr);
    check("led_read_15", rd_mid, 8'h15);
    bus_cycle(1'b0, 16'hD000, 8'hFF, 13, rd_mid, rd_end, ovr);
    bus_cycle(1'b1, 16'hD000, 8'h00, 13, rd_mid, rd_end, ovr);
    check("led_read_ff", rd_mid, 8'h3F);
    check("led_pins_ff", led, 6'b000000);

    // Buttons
    @(negedge clk); btn1 = 1'b0;
    repeat (10) @(negedge clk);
    btn1 = 1'b1;
    repeat (5) @(negedge clk);
    bus_cycle(1'b1, 16'hD001, 8'h00, 13, rd_mid, rd_end, ovr);
    check("btn1_latch", rd_mid, 8'h10);
    bus_cycle(1'b1, 16'hD001, 8'h00, 13, rd_mid, rd_end, ovr);
    check("btn_cleared", rd_mid, 8'h00);
    @(negedge clk); btn2 = 1'b0;
    repeat (5) @(negedge clk);
    bus_cycle(1'b1, 16'hD001, 8'h00, 13, rd_mid, rd_end, ovr);
    check("btn2_held", rd_mid, 8'h22);
    btn2 = 1'b1;
    repeat (5) @(negedge clk);

    // Overrun
    bus_cycle(1'b1, 16'h0123, 8'h00, 1, rd_mid, rd_end, ovr);
    check("ovr_rdata", rd_end, 8'hA5);
    check("ovr_pulses", ovr, 1);
    bus_cycle(1'b1, 16'h07FF, 8'h00, 13, rd_mid, rd_end, ovr);
    check("normal_no_ovr", ovr, 0);

    // Tick clear by write, then the next read's rise counts once
    bus_cycle(1'b0, 16'hD002, 8'h77, 13, rd_mid, rd_end, ovr);
    bus_cycle(1'b1, 16'hD002, 8'h00, 13, rd_mid, rd_end, ovr);
    check("tick_clear", rd_mid, 8'h01);

    // Reset in the middle of a write; phi2 still high at release
    @(negedge clk);
    addr = 16'hD000; rw = 1'b0; wdata = 8'h3C; phi2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    phi2 = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_led", led, 6'h3F);
    check("midrst_rdata", rdata, 8'h00);
    bus_cycle(1'b1, 16'hD002, 8'h00, 13, rd_mid, rd_end, ovr);
    check("midrst_no_false_rise", rd_mid, 8'h01);
    bus_cycle(1'b1, 16'hD000, 8'h00, 13, rd_mid, rd_end, ovr);
    check("midrst_led_read", rd_mid, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
